// File: rtl/mac512_pkg.sv
// Shared constants and issue-state type for the 256x256 MAC operand loader.
package mac512_pkg;

    localparam int WORD_W     = 32;
    localparam int OP_W       = 256;
    localparam int MAC_CYCLES = 130;

    localparam int NW    = OP_W / WORD_W;
    localparam int IDX_W = $clog2(2 * NW) + 1;
    localparam int RUN_W = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } issue_state_t;

endpackage

// File: rtl/mac512_operand_stage.sv
// Staging buffer: collects 2*NW words into stage_a then stage_b and flags a complete pair.
module mac512_operand_stage
    import mac512_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              take,
    output logic              in_ready,
    output logic [OP_W-1:0]   stage_a,
    output logic [OP_W-1:0]   stage_b,
    output logic              stage_full,
    output logic              loading
);

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_word;

    assign in_ready  = !stage_full && !flush;
    assign accept    = in_valid && in_ready;
    assign last_word = (idx == IDX_W'(2 * NW - 1));
    assign loading   = (idx != '0);

    // Flush only drops the index and flag; stale staging data is overwritten by the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            stage_full <= 1'b0;
            stage_a    <= '0;
            stage_b    <= '0;
        end else if (flush) begin
            idx        <= '0;
            stage_full <= 1'b0;
        end else begin
            if (take) begin
                stage_full <= 1'b0;
            end
            if (accept) begin
                for (int w = 0; w < NW; w++) begin
                    if (idx == IDX_W'(w)) begin
                        stage_a[w*WORD_W +: WORD_W] <= in_data;
                    end
                    if (idx == IDX_W'(w + NW)) begin
                        stage_b[w*WORD_W +: WORD_W] <= in_data;
                    end
                end
                if (last_word) begin
                    idx        <= '0;
                    stage_full <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mac512_operand_loader.sv
// Operand loader top: double-buffers A/B pairs and holds mac_en for the fixed multiply window.
module mac512_operand_loader
    import mac512_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [OP_W-1:0]   a_op,
    output logic [OP_W-1:0]   b_op,
    output logic              mac_en,
    output logic              busy,
    output logic [15:0]       op_count
);

    issue_state_t     state;
    logic [RUN_W-1:0] run_cnt;
    logic [OP_W-1:0]  stage_a;
    logic [OP_W-1:0]  stage_b;
    logic             stage_full;
    logic             loading;
    logic             take;

    // A flush in the same cycle as a pending transfer discards the pair.
    assign take = (state == IDLE) && stage_full && !flush;
    assign busy = (state == RUN) || stage_full || loading;

    mac512_operand_stage u_stage (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .flush      (flush),
        .take       (take),
        .in_ready   (in_ready),
        .stage_a    (stage_a),
        .stage_b    (stage_b),
        .stage_full (stage_full),
        .loading    (loading)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            a_op     <= '0;
            b_op     <= '0;
            mac_en   <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_op     <= stage_a;
                        b_op     <= stage_b;
                        run_cnt  <= '0;
                        op_count <= op_count + 16'd1;
                        mac_en   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (run_cnt == RUN_W'(MAC_CYCLES - 1)) begin
                        mac_en <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end
                default: begin
                    mac_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mac512_operand_loader.md
# mac512_operand_loader

Upstream feeder for the 256×256 radix-4 multiply-accumulate stage. It assembles two 256-bit operands, A then B, from a 32-bit valid/ready word stream into a staging buffer. It hands each complete pair to an active register that drives the MAC and holds the MAC enable high for the fixed multi-cycle multiply window. Double buffering lets the next pair load while the current multiply runs.

## Interface
- WORD_W, 32, input word width
- OP_W, 256, operand width; must be an integer multiple of WORD_W
- MAC_CYCLES, 130, cycles mac_en is held per operand pair; must be ≥ 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  WORD_W  operand word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a word
- flush  in  1  synchronous clear of a partially or fully loaded staging buffer
- a_op  out  OP_W  operand A to MAC
- b_op  out  OP_W  operand B to MAC
- mac_en  out  1  MAC enable; a_op and b_op are stable whenever it is high
- busy  out  1  MAC window active, or staging buffer non-empty
- op_count  out  16  number of pairs issued to the MAC; wraps

## Operation
- NW = OP_W/WORD_W (8 by default). Word index 0..2·NW-1 with a 5-bit counter at defaults.
  - Word i < NW goes to stage_a[i·WORD_W +: WORD_W], so word 0 is the LSW of A.
  - Word i ≥ NW goes to stage_b[(i-NW)·WORD_W +: WORD_W].
- Accept a word when in_valid && in_ready. in_ready = !stage_full && !flush.
- On acceptance of word 2·NW-1: set stage_full and reset the word index to 0.
- Issue side FSM:
  - IDLE → RUN when stage_full is set. At that edge:
    - a_op ← stage_a and b_op ← stage_b;
    - stage_full is cleared;
    - run_cnt ← 0;
    - op_count increments, wrapping modulo 2^16.
  - RUN: mac_en = 1; run_cnt increments each cycle.
  - RUN → IDLE at the edge where run_cnt == MAC_CYCLES-1.
  - IDLE: mac_en = 0. a_op and b_op keep their last values.
- flush:
  - Clears the word index and stage_full.
  - Does not affect the RUN state, a_op, b_op, or op_count.
  - If flush and stage_full are both set while IDLE, flush wins and no transfer occurs.
- busy = (state == RUN) || stage_full || (word index != 0).
- Staging registers are not cleared by flush; only the index and flag are. Stale data is always overwritten before the next transfer.

## Timing
- Reset values: in_ready=1, mac_en=0, busy=0, a_op=0, b_op=0, op_count=0. The FSM resets to IDLE; word index, stage_full, and run_cnt reset to 0.
- Last word accepted at edge k: stage_full=1 from k, so in_ready=0 in cycle k+1.
  - If IDLE at edge k+1: transfer occurs. mac_en is high from k+1 through edge k+1+MAC_CYCLES, exactly MAC_CYCLES cycles. in_ready=1 again from k+1.
- Pair completed while in RUN: it is held in staging with in_ready=0. Transfer happens at the first edge in IDLE. This gives a minimum 1-cycle mac_en-low gap between pairs.
- Minimum period between issues: MAC_CYCLES+1 cycles when staging is already full.
- Input throughput: 1 word/cycle while !stage_full. in_valid gaps stall the index without loss.
- rst asserted mid-load or mid-RUN: all state returns to reset values immediately. The partially loaded pair is discarded and mac_en drops asynchronously.

## Structure
- Shared package mac512_pkg:
  - WORD_W, OP_W, and MAC_CYCLES defaults;
  - derived NW;
  - issue-state typedef {IDLE, RUN}.
- One natural sub-module, mac512_operand_stage: the word-index counter plus the stage_a/stage_b write-demux and the stage_full flag.
- Issue FSM, active registers, and op_count stay in the top.

## Test plan
- Basic issue:
  - Stimulus: after reset, stream word0=32, words1–7=0, word8=32, words9–15=0 back-to-back.
  - Response: a_op=32, b_op=32; mac_en rises 1 cycle after the 16th accept and stays high exactly 130 cycles; op_count=1.
- Double buffer:
  - Stimulus: during the first RUN, load A=5, B=10.
  - Response: in_ready=0 after the 16th word. a_op=5 and b_op=10 appear one cycle after mac_en falls; mac_en is low for exactly 1 cycle between runs; op_count=2.
- Backpressure and gaps:
  - Stimulus: A=100, B=100 with in_valid toggled every other cycle.
  - Response: correct operands after 16 accepts. No word accepted while in_ready=0 even though in_valid is high.
- Flush:
  - Stimulus: assert flush after 9 words while IDLE.
  - Response: word index=0 and busy=0; no mac_en. The next 16 words form a clean pair with no remnant.
- Flush during RUN:
  - Stimulus: assert flush with staging full during RUN.
  - Response: current mac_en window completes at full length; no second issue; op_count unchanged.
- Reset:
  - Stimulus: rst pulsed at run_cnt=60.
  - Response: mac_en=0 immediately; a_op=0, b_op=0, op_count=0, in_ready=1; the next load issues normally.
